srt_quotient_collector: RTL and testbench

//  Receiving end of the radix-4 SRT divider control's shiftq/doneq strobes. Assembles the redundant

---
 rtl/srt_div_pkg.sv | 31 +++
 rtl/srt_otf_conv.sv | 63 ++++++
 rtl/srt_quotient_collector.sv | 155 +++++++++++++++
 tb/tb_srt_quotient_collector.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/srt_div_pkg.sv
// Shared definitions for the radix-4 SRT divider: digit encodings, default sizes
// and the quotient-collector state encoding.
package srt_div_pkg;

  localparam int NDIG_DEF = 24;
  localparam int RW_DEF   = 28;

  // Signed two's-complement quotient digits, 3 bits wide
  localparam logic [2:0] QD_P2 = 3'b010;
  localparam logic [2:0] QD_P1 = 3'b001;
  localparam logic [2:0] QD_Z  = 3'b000;
  localparam logic [2:0] QD_M1 = 3'b111;
  localparam logic [2:0] QD_M2 = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_CORRECT,
    ST_HOLD
  } coll_state_e;

  function automatic logic qd_legal(input logic [2:0] d);
    logic ok;
    case (d)
      QD_P2, QD_P1, QD_Z, QD_M1, QD_M2: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/srt_otf_conv.sv
// On-the-fly conversion of signed radix-4 digits into a binary quotient Q and its
// predecessor QM = Q - 1, so a negative remainder is corrected by selecting QM.
module srt_otf_conv
  import srt_div_pkg::*;
#(
  parameter int QW = 48
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear_i,
  input  logic          shift_i,
  input  logic [2:0]    digit_i,
  output logic [QW-1:0] q_o,
  output logic [QW-1:0] qm_o,
  output logic          illegal_o
);

  logic [QW-1:0] q_q, q_d;
  logic [QW-1:0] qm_q, qm_d;
  logic [2:0]    dig;
  logic [2:0]    dig_m1;
  logic [2:0]    dig_p3;

  // An illegal digit is folded to zero; the caller records the error.
  always_comb begin
    illegal_o = !qd_legal(digit_i);
    dig       = illegal_o ? QD_Z : digit_i;
    dig_m1    = dig - 3'd1;
    dig_p3    = dig + 3'd3;
  end

  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise a missed branch infers a latch.
  always_comb begin
    q_d  = q_q;
    qm_d = qm_q;
    if (clear_i) begin
      q_d  = '0;
      qm_d = '1;
    end else if (shift_i) begin
      // For negative digits (4+q)[1:0] equals q[1:0]; only the source register changes.
      q_d  = dig[2] ? {qm_q[QW-3:0], dig[1:0]} : {q_q[QW-3:0], dig[1:0]};
      qm_d = (!dig[2] && (dig != QD_Z)) ? {q_q[QW-3:0], dig_m1[1:0]}
                                        : {qm_q[QW-3:0], dig_p3[1:0]};
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_q  <= '0;
      qm_q <= '1;
    end else begin
      q_q  <= q_d;
      qm_q <= qm_d;
    end
  end

  assign q_o  = q_q;
  assign qm_o = qm_q;

endmodule

// File: rtl/srt_quotient_collector.sv
// Collects SRT quotient digits, applies final remainder sign correction and
// presents quotient/remainder on a valid/ready handshake.
module srt_quotient_collector
  import srt_div_pkg::*;
#(
  parameter int NDIG = NDIG_DEF,
  parameter int RW   = RW_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              shiftq,
  input  logic [2:0]        q_digit,
  input  logic              doneq,
  input  logic [RW-1:0]     rem_in,
  input  logic [RW-1:0]     divisor,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*NDIG-1:0] quotient,
  output logic [RW-1:0]     remainder,
  output logic              digit_err,
  output logic              ovf,
  output logic              busy
);

  localparam int QW = 2 * NDIG;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] NDIG_C = CW'(NDIG);

  coll_state_e   state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          derr_q, derr_d;
  logic          ovf_q, ovf_d;
  logic          rv_q, rv_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [RW-1:0] div_q, div_d;
  logic [QW-1:0] quot_q, quot_d;
  logic [RW-1:0] remo_q, remo_d;

  logic          accept_digit;
  logic [QW-1:0] otf_q, otf_qm;
  logic          digit_illegal;

  assign accept_digit = (state_q == ST_ACCUM) && shiftq && !start && (dcnt_q < NDIG_C);

  srt_otf_conv #(.QW(QW)) u_otf (
    .clk       (clk),
    .resetn    (resetn),
    .clear_i   (start),
    .shift_i   (accept_digit),
    .digit_i   (q_digit),
    .q_o       (otf_q),
    .qm_o      (otf_qm),
    .illegal_o (digit_illegal)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // start restarts from any state, abandoning a pending result.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM:   if (doneq) state_d = ST_CORRECT;
        ST_CORRECT: state_d = ST_HOLD;
        ST_HOLD:    if (rv_q && res_ready) state_d = ST_IDLE;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  always_comb begin
    dcnt_d = dcnt_q;
    derr_d = derr_q;
    ovf_d  = ovf_q;
    rv_d   = rv_q;
    rem_d  = rem_q;
    div_d  = div_q;
    quot_d = quot_q;
    remo_d = remo_q;
    if (start) begin
      dcnt_d = '0;
      derr_d = 1'b0;
      ovf_d  = 1'b0;
      rv_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (shiftq) begin
            if (dcnt_q < NDIG_C) begin
              dcnt_d = dcnt_q + CW'(1);
              if (digit_illegal) derr_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (doneq) begin
            rem_d = rem_in;
            div_d = divisor;
          end
        end
        ST_CORRECT: begin
          // A negative remainder means the quotient overshot by one: use QM.
          if (rem_q[RW-1]) begin
            quot_d = otf_qm;
            remo_d = rem_q + div_q;
          end else begin
            quot_d = otf_q;
            remo_d = rem_q;
          end
        end
        ST_HOLD: rv_d = !(rv_q && res_ready);
        default: rv_d = rv_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dcnt_q <= '0;
      derr_q <= 1'b0;
      ovf_q  <= 1'b0;
      rv_q   <= 1'b0;
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      remo_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
      derr_q <= derr_d;
      ovf_q  <= ovf_d;
      rv_q   <= rv_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      quot_q <= quot_d;
      remo_q <= remo_d;
    end
  end

  assign res_valid = rv_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign digit_err = derr_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_srt_quotient_collector.sv
// Directed self-checking bench for srt_quotient_collector with NDIG=4, RW=8.
module tb_srt_quotient_collector;

  localparam int NDIG = 4;
  localparam int RW   = 8;
  localparam int QW   = 2 * NDIG;

  localparam logic [2:0] D_P2 = 3'b010;
  localparam logic [2:0] D_P1 = 3'b001;
  localparam logic [2:0] D_Z  = 3'b000;
  localparam logic [2:0] D_M1 = 3'b111;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          shiftq;
  logic [2:0]    q_digit;
  logic          doneq;
  logic [RW-1:0] rem_in;
  logic [RW-1:0] divisor;
  logic          res_valid;
  logic          res_ready;
  logic [QW-1:0] quotient;
  logic [RW-1:0] remainder;
  logic          digit_err;
  logic          ovf;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  srt_quotient_collector #(.NDIG(NDIG), .RW(RW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .shiftq    (shiftq),
    .q_digit   (q_digit),
    .doneq     (doneq),
    .rem_in    (rem_in),
    .divisor   (divisor),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .digit_err (digit_err),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens on the falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic strobe(input logic [2:0] d);
    shiftq  = 1'b1;
    q_digit = d;
    @(negedge clk);
    shiftq  = 1'b0;
    q_digit = D_Z;
  endtask

  // doneq sampled at edge k; res_valid must be low after k+1 and high after k+2.
  task automatic finish_div(input string tag, input logic [RW-1:0] r, input logic [RW-1:0] d);
    doneq   = 1'b1;
    rem_in  = r;
    divisor = d;
    @(negedge clk);
    doneq   = 1'b0;
    rem_in  = '0;
    divisor = '0;
    @(negedge clk);
    check({tag, "_valid_k1"}, res_valid, 0);
    @(negedge clk);
    check({tag, "_valid_k2"}, res_valid, 1);
  endtask

  task automatic accept(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_after_accept"}, res_valid, 0);
    check({tag, "_busy_after_accept"}, busy, 0);
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    shiftq    = 1'b0;
    q_digit   = D_Z;
    doneq     = 1'b0;
    rem_in    = '0;
    divisor   = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_derr", digit_err, 0);
    check("rst_ovf", ovf, 0);
    resetn = 1'b1;
    @(negedge clk);

    // +1,+2,0,-1 = 64+32+0-1 = 95; positive remainder kept
    pulse_start();
    check("t1_busy", busy, 1);
    strobe(D_P1); strobe(D_P2); strobe(D_Z); strobe(D_M1);
    finish_div("t1", 8'd5, 8'd7);
    check("t1_quot", quotient, 8'h5F);
    check("t1_rem", remainder, 8'd5);
    check("t1_derr", digit_err, 0);
    check("t1_ovf", ovf, 0);
    accept("t1");

    // Same digits, last one together with doneq; negative remainder -> QM, -3+7
    pulse_start();
    strobe(D_P1); strobe(D_P2); strobe(D_Z);
    shiftq  = 1'b1;
    q_digit = D_M1;
    doneq   = 1'b1;
    rem_in  = 8'hFD;
    divisor = 8'd7;
    @(negedge clk);
    shiftq  = 1'b0;
    doneq   = 1'b0;
    rem_in  = '0;
    divisor = '0;
    @(negedge clk);
    check("t2_valid_k1", res_valid, 0);
    @(negedge clk);
    check("t2_valid_k2", res_valid, 1);
    check("t2_quot", quotient, 8'h5E);
    check("t2_rem", remainder, 8'd4);
    accept("t2");

    // Illegal +3 counted as 0: digits 0,+1,+2,0 = 16+8 = 0x18
    pulse_start();
    strobe(3'b011);
    check("t3_derr_live", digit_err, 1);
    strobe(D_P1); strobe(D_P2); strobe(D_Z);
    finish_div("t3", 8'd1, 8'd7);
    check("t3_quot", quotient, 8'h18);
    check("t3_derr", digit_err, 1);
    check("t3_ovf", ovf, 0);
    accept("t3");

    // Five +1 strobes: fifth overflows; outputs hold while not accepted
    pulse_start();
    for (int i = 0; i < 5; i++) strobe(D_P1);
    check("t4_ovf_live", ovf, 1);
    finish_div("t4", 8'd2, 8'd7);
    check("t4_quot", quotient, 8'h55);
    check("t4_rem", remainder, 8'd2);
    check("t4_ovf", ovf, 1);
    check("t4_derr", digit_err, 0);
    for (int i = 0; i < 10; i++) begin
      shiftq  = 1'b1;
      q_digit = D_P2;
      doneq   = (i == 3);
      rem_in  = 8'hF0;
      @(negedge clk);
      check("t4_hold_valid", res_valid, 1);
      check("t4_hold_quot", quotient, 8'h55);
      check("t4_hold_rem", remainder, 8'd2);
    end
    shiftq = 1'b0;
    doneq  = 1'b0;
    rem_in = '0;
    accept("t4");

    // Restart mid-accumulation discards digits and flags
    pulse_start();
    strobe(3'b100);
    strobe(D_P1);
    check("t5_derr_before", digit_err, 1);
    pulse_start();
    check("t5_derr_cleared", digit_err, 0);
    check("t5_busy", busy, 1);
    for (int i = 0; i < 4; i++) strobe(D_P2);
    finish_div("t5", 8'd0, 8'd7);
    check("t5_quot", quotient, 8'hAA);
    check("t5_derr", digit_err, 0);
    check("t5_ovf", ovf, 0);
    accept("t5");

    // Async reset during accumulation
    pulse_start();
    strobe(D_P1);
    strobe(D_P2);
    #2 resetn = 1'b0;
    #1;
    check("t6_busy_rst", busy, 0);
    check("t6_valid_rst", res_valid, 0);
    check("t6_quot_rst", quotient, 0);
    @(negedge clk);
    resetn = 1'b1;
    shiftq  = 1'b1;
    q_digit = D_P1;
    doneq   = 1'b1;
    rem_in  = 8'd3;
    divisor = 8'd7;
    repeat (3) @(negedge clk);
    shiftq = 1'b0;
    doneq  = 1'b0;
    check("t6_busy_ignored", busy, 0);
    check("t6_valid_ignored", res_valid, 0);
    check("t6_quot_ignored", quotient, 0);

    // Early doneq after one digit: right-aligned result
    pulse_start();
    strobe(D_P2);
    finish_div("t7", 8'd0, 8'd7);
    check("t7_quot", quotient, 8'h02);
    accept("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
